swc_packet_mem_read_pump: RTL and testbench
===========================================

SWC_PACKET_MEM_READ_PUMP -- requirements
Module: swc_packet_mem_read_pump

Interface
REQ-001 Parameters SHALL be: PAGE_ADDR_BITS, 10, page number width; DATA_WIDTH, 20, narrow word width; MULTIPLY, 16, words per memory line; LINES_PER_PAGE, 8, lines per page (page = 128 words).
REQ-002 clk_i  in  1  single clock; all logic on rising edge.
REQ-003 rst_n_i  in  1  asynchronous, active-low reset.
REQ-004 pgaddr_i  in  PAGE_ADDR_BITS  first page of packet; pgreq_i  in  1  one-cycle load strobe.
REQ-005 pgend_o  out  1  one-cycle pulse when the last line of a page is captured.
REQ-006 sync_i  in  1  memory access slot for this port, high one cycle in every MULTIPLY.
REQ-007 rd_o  out  1  memory read strobe; addr_o  out  PAGE_ADDR_BITS+3  {page, line}.
REQ-008 d_i  in  DATA_WIDTH*MULTIPLY  memory read data, valid exactly one cycle after rd_o.
REQ-009 ll_addr_o  out  PAGE_ADDR_BITS  page being looked up; ll_data_i  in  PAGE_ADDR_BITS  next page; ll_rd_req_o  out  1; ll_rd_done_i  in  1.
REQ-010 q_o  out  DATA_WIDTH  output word; drdy_o  out  1  q_o valid; dreq_i  in  1  consumer accepts; transfer = drdy_o & dreq_i.
REQ-011 flush_i  in  1  end of packet; discard buffered data.

Function
REQ-012 States SHALL be IDLE, WAIT_SYNC, FETCH, SERVE.
REQ-013 pgreq_i in any state: page <= pgaddr_i, line <= 0, buffer discarded, pending LL result discarded, state -> WAIT_SYNC next cycle.
REQ-014 WAIT_SYNC: when sync_i=1 and no LL lookup outstanding, rd_o=1 for exactly that cycle, addr_o={page,line}; state -> FETCH.
REQ-015 FETCH: d_i captured into the line register, word index <= 0, line <= line+1 mod 8; state -> SERVE.
REQ-016 If the captured line was 7: pgend_o pulses in the FETCH cycle, ll_rd_req_o asserts next cycle with ll_addr_o=page, held high until ll_rd_done_i=1.
REQ-017 On the ll_rd_done_i cycle: page <= ll_data_i, ll_rd_req_o deasserts next cycle; ll_rd_done_i while ll_rd_req_o=0 SHALL be ignored.
REQ-018 SERVE: drdy_o=1; q_o = line bits [idx*DATA_WIDTH +: DATA_WIDTH], word 0 in LSBs; each transfer increments idx.
REQ-019 Transfer at idx=15: drdy_o=0 next cycle, state -> WAIT_SYNC; no word lost or repeated across lines or pages.
REQ-020 Latency: first word valid on drdy_o no earlier than 2 cycles after the sync_i cycle used for the read.
REQ-021 dreq_i=0 in SERVE: q_o and idx held stable indefinitely.
REQ-022 flush_i (without pgreq_i): state -> IDLE and drdy_o=0 next cycle; an outstanding ll_rd_req_o stays high until ll_rd_done_i, result discarded.
REQ-023 flush_i and pgreq_i in the same cycle: pgreq_i wins (REQ-013).
REQ-024 IDLE: rd_o, drdy_o, pgend_o held 0; sync_i ignored.

Reset
REQ-025 While rst_n_i=0: state=IDLE; rd_o, drdy_o, pgend_o, ll_rd_req_o = 0; addr_o, ll_addr_o, q_o, page, line, idx = 0.
REQ-026 Reset asserted mid-transfer or mid-LL-lookup SHALL abort immediately with no further strobe after release until a new pgreq_i.

Structure
REQ-027 PAGE_ADDR_BITS, DATA_WIDTH, MULTIPLY, LINES_PER_PAGE and the state encoding SHALL live in the shared swc_pump_pkg package, also used by the write pump.
REQ-028 The LL lookup handshake (REQ-016/017/022) SHALL be one sub-module, swc_pump_ll_fetch.

Verification
REQ-029 pgreq_i with pgaddr_i=3, dreq_i=1, sync every 16 cycles, line data word k=k -> rd_o with addr_o=0x18, q_o sequence 0..15, then addr_o=0x19.
REQ-030 Read 8 lines from page 3, ll_rd_done_i 4 cycles after ll_rd_req_o with ll_data_i=9 -> pgend_o one pulse, ll_addr_o=3, next rd_o addr_o=0x48.
REQ-031 dreq_i toggled 1/0 every cycle -> exactly 16 transfers per line, q_o stable while dreq_i=0.
REQ-032 flush_i at word 5 of line 2 -> drdy_o=0 next cycle, no rd_o until pgreq_i; next pgreq_i pgaddr_i=7 -> addr_o=0x38.
REQ-033 flush_i and pgreq_i same cycle (pgaddr_i=5) during LL lookup -> late ll_data_i ignored, next addr_o=0x28.
REQ-034 rst_n_i low during SERVE -> all outputs 0 same cycle, stay 0 after release until pgreq_i.

Source files
------------

// File: rtl/swc_pump_pkg.sv
// Shared constants and state encoding for the packet-memory read/write pumps.
package swc_pump_pkg;

   localparam int PAGE_ADDR_BITS = 10;   // page number width
   localparam int DATA_WIDTH     = 20;   // narrow word width
   localparam int MULTIPLY       = 16;   // narrow words per memory line
   localparam int LINES_PER_PAGE = 8;    // memory lines per page

   localparam int LINE_BITS      = $clog2(LINES_PER_PAGE);
   localparam int IDX_BITS       = $clog2(MULTIPLY);
   localparam int ADDR_BITS      = PAGE_ADDR_BITS + LINE_BITS;
   localparam int LINE_DATA_BITS = DATA_WIDTH * MULTIPLY;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_SYNC = 2'd1,
      ST_FETCH     = 2'd2,
      ST_SERVE     = 2'd3
   } pump_state_t;

endpackage

// File: rtl/swc_pump_ll_fetch.sv
// Linked-list lookup handshake: asks for the page that follows the current one.
// A lookup, once issued, always runs to ll_rd_done_i; an abort while it is
// outstanding only marks the eventual result to be thrown away.
module swc_pump_ll_fetch
   import swc_pump_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      start_i,      // last line of page captured
   input  logic [PAGE_ADDR_BITS-1:0] page_i,       // page to look up
   input  logic                      abort_i,      // pgreq or flush from the pump
   output logic [PAGE_ADDR_BITS-1:0] ll_addr_o,
   input  logic [PAGE_ADDR_BITS-1:0] ll_data_i,
   output logic                      ll_rd_req_o,
   input  logic                      ll_rd_done_i,
   output logic                      upd_o,        // load next_page_o into the page register
   output logic [PAGE_ADDR_BITS-1:0] next_page_o
);

   logic discard;

   // Request/hold/release of the lookup and tracking of a discarded result.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ll_rd_req_o <= 1'b0;
         ll_addr_o   <= '0;
         discard     <= 1'b0;
      end else if (start_i) begin
         ll_rd_req_o <= 1'b1;
         ll_addr_o   <= page_i;
         discard     <= abort_i;
      end else if (ll_rd_req_o && ll_rd_done_i) begin
         ll_rd_req_o <= 1'b0;
         discard     <= 1'b0;
      end else if (ll_rd_req_o && abort_i) begin
         discard     <= 1'b1;
      end
   end

   // A done pulse with no request outstanding is ignored.
   assign upd_o       = ll_rd_req_o & ll_rd_done_i & ~discard & ~abort_i;
   assign next_page_o = ll_data_i;

endmodule

// File: rtl/swc_packet_mem_read_pump.sv
// Packet-memory read pump: reads wide lines in this port's memory slot and
// serialises them into narrow words, following the page linked list.
//
// Output handshake: q_o is valid while drdy_o=1; a word moves when
// drdy_o & dreq_i on a rising edge. While dreq_i=0, q_o and the word index
// are held unchanged for as long as needed.
module swc_packet_mem_read_pump
   import swc_pump_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic [PAGE_ADDR_BITS-1:0] pgaddr_i,
   input  logic                      pgreq_i,
   output logic                      pgend_o,
   input  logic                      sync_i,
   output logic                      rd_o,
   output logic [ADDR_BITS-1:0]      addr_o,
   input  logic [LINE_DATA_BITS-1:0] d_i,
   output logic [PAGE_ADDR_BITS-1:0] ll_addr_o,
   input  logic [PAGE_ADDR_BITS-1:0] ll_data_i,
   output logic                      ll_rd_req_o,
   input  logic                      ll_rd_done_i,
   output logic [DATA_WIDTH-1:0]     q_o,
   output logic                      drdy_o,
   input  logic                      dreq_i,
   input  logic                      flush_i,
   output logic [1:0]                state_o       // debug view of the FSM
);

   localparam logic [LINE_BITS-1:0] LINE_LAST = LINE_BITS'(LINES_PER_PAGE - 1);
   localparam logic [IDX_BITS-1:0]  IDX_LAST  = IDX_BITS'(MULTIPLY - 1);

   pump_state_t                state;
   logic [PAGE_ADDR_BITS-1:0]  page;
   logic [LINE_BITS-1:0]       line;
   logic [IDX_BITS-1:0]        idx;
   logic [LINE_DATA_BITS-1:0]  line_q;

   logic                       ll_start;
   logic                       ll_abort;
   logic                       ll_upd;
   logic [PAGE_ADDR_BITS-1:0]  ll_next;

   // The last line of a page is being captured: announce it and start the lookup.
   assign ll_start = (state == ST_FETCH) && (line == LINE_LAST);
   assign ll_abort = pgreq_i | flush_i;
   assign pgend_o  = ll_start;

   // The read must land in the sync cycle itself, so the strobe is decoded
   // from registered state plus the slot; the next page must be known first.
   assign rd_o    = (state == ST_WAIT_SYNC) & sync_i & ~ll_rd_req_o & ~pgreq_i & ~flush_i;
   assign addr_o  = {page, line};
   assign q_o     = line_q[idx*DATA_WIDTH +: DATA_WIDTH];
   assign state_o = state;

   swc_pump_ll_fetch u_ll_fetch (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .start_i      (ll_start),
      .page_i       (page),
      .abort_i      (ll_abort),
      .ll_addr_o    (ll_addr_o),
      .ll_data_i    (ll_data_i),
      .ll_rd_req_o  (ll_rd_req_o),
      .ll_rd_done_i (ll_rd_done_i),
      .upd_o        (ll_upd),
      .next_page_o  (ll_next)
   );

   // Main pump FSM: page load, slot wait, line capture, word serving.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state  <= ST_IDLE;
         page   <= '0;
         line   <= '0;
         idx    <= '0;
         line_q <= '0;
         drdy_o <= 1'b0;
      end else if (pgreq_i) begin
         // A new packet overrides everything, including a same-cycle flush.
         page   <= pgaddr_i;
         line   <= '0;
         idx    <= '0;
         drdy_o <= 1'b0;
         state  <= ST_WAIT_SYNC;
      end else begin
         if (ll_upd) begin
            page <= ll_next;
         end
         if (flush_i) begin
            drdy_o <= 1'b0;
            state  <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  drdy_o <= 1'b0;
               end
               ST_WAIT_SYNC: begin
                  if (rd_o) begin
                     state <= ST_FETCH;
                  end
               end
               ST_FETCH: begin
                  line_q <= d_i;
                  idx    <= '0;
                  line   <= line + 1'b1;
                  drdy_o <= 1'b1;
                  state  <= ST_SERVE;
               end
               ST_SERVE: begin
                  if (dreq_i) begin
                     if (idx == IDX_LAST) begin
                        drdy_o <= 1'b0;
                        state  <= ST_WAIT_SYNC;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end
               end
               default: begin
                  drdy_o <= 1'b0;
                  state  <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_swc_packet_mem_read_pump.sv
// Directed bench for the packet-memory read pump.
module tb_swc_packet_mem_read_pump;
   import swc_pump_pkg::*;

   logic                      clk_i;
   logic                      rst_n_i;
   logic [PAGE_ADDR_BITS-1:0] pgaddr_i;
   logic                      pgreq_i;
   logic                      pgend_o;
   logic                      sync_i;
   logic                      rd_o;
   logic [ADDR_BITS-1:0]      addr_o;
   logic [LINE_DATA_BITS-1:0] d_i;
   logic [PAGE_ADDR_BITS-1:0] ll_addr_o;
   logic [PAGE_ADDR_BITS-1:0] ll_data_i;
   logic                      ll_rd_req_o;
   logic                      ll_rd_done_i;
   logic [DATA_WIDTH-1:0]     q_o;
   logic                      drdy_o;
   logic                      dreq_i;
   logic                      flush_i;
   logic [1:0]                state_o;

   swc_packet_mem_read_pump dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .pgaddr_i     (pgaddr_i),
      .pgreq_i      (pgreq_i),
      .pgend_o      (pgend_o),
      .sync_i       (sync_i),
      .rd_o         (rd_o),
      .addr_o       (addr_o),
      .d_i          (d_i),
      .ll_addr_o    (ll_addr_o),
      .ll_data_i    (ll_data_i),
      .ll_rd_req_o  (ll_rd_req_o),
      .ll_rd_done_i (ll_rd_done_i),
      .q_o          (q_o),
      .drdy_o       (drdy_o),
      .dreq_i       (dreq_i),
      .flush_i      (flush_i),
      .state_o      (state_o)
   );

   // ---------------- clock ----------------
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // ---------------- bench state ----------------
   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int sync_cnt = 0;
   logic [DATA_WIDTH-1:0] exp_q[$];
   logic [DATA_WIDTH-1:0] got_q[$];
   logic [ADDR_BITS-1:0]  rd_q[$];
   int                    wc_q[$];
   int                    rd_cyc_q[$];
   int  first_drdy, pgend_cnt, drdy_cnt, stable_err, ll_age, ll_delay, n0;
   bit  plain_data, ll_auto, dreq_toggle, ll_seen, prev_hold, rd_seen;
   logic [PAGE_ADDR_BITS-1:0] ll_seen_addr;
   logic [DATA_WIDTH-1:0]     prev_q;
   logic [ADDR_BITS-1:0]      rd_addr_seen;

   // Memory content model: plain mode gives word k = k, otherwise word k
   // carries its line address so lost or repeated words are visible.
   function automatic logic [DATA_WIDTH-1:0] word_of(input logic [ADDR_BITS-1:0] a, input int k);
      logic [3:0] kk;
      kk = 4'(k);
      if (plain_data) return DATA_WIDTH'(k);
      return DATA_WIDTH'({a, kk});
   endfunction

   function automatic logic [LINE_DATA_BITS-1:0] make_line(input logic [ADDR_BITS-1:0] a);
      logic [LINE_DATA_BITS-1:0] l;
      l = '0;
      for (int k = 0; k < MULTIPLY; k++) l[k*DATA_WIDTH +: DATA_WIDTH] = word_of(a, k);
      return l;
   endfunction

   function automatic logic [ADDR_BITS-1:0] rd_at(input int i);
      if (i < rd_q.size()) return rd_q[i];
      return '1;
   endfunction

   function automatic int wc_at(input int i);
      if (i < wc_q.size()) return wc_q[i];
      return -1000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs on the falling edge, update inputs after the rise.
   task automatic cyc();
      @(negedge clk_i);
      rd_seen = rd_o;
      rd_addr_seen = addr_o;
      if (rd_o) begin
         rd_q.push_back(addr_o);
         wc_q.push_back(got_q.size());
         rd_cyc_q.push_back(cycle);
      end
      if (pgend_o) pgend_cnt++;
      if (drdy_o) begin
         drdy_cnt++;
         if (first_drdy < 0) first_drdy = cycle;
      end
      if (prev_hold && drdy_o && (q_o !== prev_q)) stable_err++;
      prev_hold = drdy_o && !dreq_i;
      prev_q = q_o;
      if (drdy_o && dreq_i) got_q.push_back(q_o);
      if (ll_rd_req_o && !ll_seen) begin
         ll_seen = 1'b1;
         ll_seen_addr = ll_addr_o;
      end
      if (ll_rd_req_o && !ll_rd_done_i) ll_age++;
      else if (!ll_rd_req_o) ll_age = 0;
      @(posedge clk_i);
      #1;
      cycle++;
      d_i = rd_seen ? make_line(rd_addr_seen) : '0;
      sync_cnt = (sync_cnt + 1) % MULTIPLY;
      sync_i = (sync_cnt == 0);
      if (dreq_toggle) dreq_i = ~dreq_i;
      if (ll_auto) ll_rd_done_i = ll_rd_req_o && (ll_age == ll_delay);
   endtask

   task automatic clear_obs();
      exp_q.delete();
      got_q.delete();
      rd_q.delete();
      wc_q.delete();
      rd_cyc_q.delete();
      first_drdy = -1;
      pgend_cnt = 0;
      drdy_cnt = 0;
      stable_err = 0;
      ll_seen = 1'b0;
      ll_seen_addr = '0;
      prev_hold = 1'b0;
   endtask

   task automatic pulse_pgreq(input logic [PAGE_ADDR_BITS-1:0] a);
      pgaddr_i = a;
      pgreq_i = 1'b1;
      cyc();
      pgreq_i = 1'b0;
   endtask

   task automatic wait_rd(input int n, input int budget, input string tag);
      int b;
      b = 0;
      while (rd_q.size() < n && b < budget) begin
         cyc();
         b++;
      end
      chk(tag, 64'(rd_q.size() >= n), 64'd1);
   endtask

   task automatic push_line(input logic [ADDR_BITS-1:0] a);
      for (int k = 0; k < MULTIPLY; k++) exp_q.push_back(word_of(a, k));
   endtask

   task automatic compare_words(input string tag);
      chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int b;
      rst_n_i = 1'b0;
      pgaddr_i = '0;
      pgreq_i = 1'b0;
      sync_i = 1'b0;
      d_i = '0;
      ll_data_i = 10'd9;
      ll_rd_done_i = 1'b0;
      dreq_i = 1'b0;
      flush_i = 1'b0;
      plain_data = 1'b1;
      ll_auto = 1'b1;
      ll_delay = 4;
      dreq_toggle = 1'b0;
      ll_age = 0;
      clear_obs();
      repeat (3) cyc();

      // Reset values while rst_n_i is low.
      chk("rst_state", 64'(state_o), 64'd0);
      chk("rst_rd", 64'(rd_o), 64'd0);
      chk("rst_drdy", 64'(drdy_o), 64'd0);
      chk("rst_pgend", 64'(pgend_o), 64'd0);
      chk("rst_llreq", 64'(ll_rd_req_o), 64'd0);
      chk("rst_addr", 64'(addr_o), 64'd0);
      chk("rst_lladdr", 64'(ll_addr_o), 64'd0);
      chk("rst_q", 64'(q_o), 64'd0);

      // IDLE ignores sync.
      rst_n_i = 1'b1;
      repeat (20) cyc();
      chk("idle_no_rd", 64'(rd_q.size()), 64'd0);
      chk("idle_no_drdy", 64'(drdy_cnt), 64'd0);

      // Page 3, plain data, consumer always ready.
      clear_obs();
      dreq_i = 1'b1;
      pulse_pgreq(10'd3);
      wait_rd(2, 100, "s1_rd_seen");
      chk("s1_addr0", 64'(rd_at(0)), 64'h18);
      chk("s1_addr1", 64'(rd_at(1)), 64'h19);
      chk("s1_latency", 64'(first_drdy - ((rd_cyc_q.size() > 0) ? rd_cyc_q[0] : 0)), 64'd2);
      for (int k = 0; k < 16; k++) exp_q.push_back(DATA_WIDTH'(k));
      compare_words("s1");

      // Whole page 3 then page 9 from the linked list.
      clear_obs();
      plain_data = 1'b0;
      pulse_pgreq(10'd3);
      wait_rd(9, 700, "s2_rd_seen");
      chk("s2_pgend_cnt", 64'(pgend_cnt), 64'd1);
      chk("s2_ll_addr", 64'(ll_seen_addr), 64'd3);
      chk("s2_addr7", 64'(rd_at(7)), 64'h1F);
      chk("s2_addr8", 64'(rd_at(8)), 64'h48);
      for (int a = 8'h18; a <= 8'h1F; a++) push_line(ADDR_BITS'(a));
      compare_words("s2");

      // Consumer toggling every cycle.
      clear_obs();
      dreq_toggle = 1'b1;
      pulse_pgreq(10'd2);
      wait_rd(3, 400, "s3_rd_seen");
      chk("s3_line0_xfers", 64'(wc_at(1) - wc_at(0)), 64'd16);
      chk("s3_line1_xfers", 64'(wc_at(2) - wc_at(1)), 64'd16);
      chk("s3_stable", 64'(stable_err), 64'd0);
      push_line(ADDR_BITS'(8'h10));
      push_line(ADDR_BITS'(8'h11));
      compare_words("s3");
      dreq_toggle = 1'b0;
      dreq_i = 1'b1;

      // Flush at word 5 of line 2.
      clear_obs();
      pulse_pgreq(10'd1);
      wait_rd(3, 200, "s4_rd_seen");
      b = 0;
      while (got_q.size() < 37 && b < 60) begin
         cyc();
         b++;
      end
      chk("s4_words_before", 64'(got_q.size()), 64'd37);
      chk("s4_drdy_at5", 64'(drdy_o), 64'd1);
      chk("s4_q_at5", 64'(q_o), 64'(word_of(ADDR_BITS'(8'h0A), 5)));
      flush_i = 1'b1;
      dreq_i = 1'b0;
      cyc();
      flush_i = 1'b0;
      dreq_i = 1'b1;
      chk("s4_drdy_after", 64'(drdy_o), 64'd0);
      chk("s4_state_after", 64'(state_o), 64'd0);
      n0 = rd_q.size();
      drdy_cnt = 0;
      repeat (40) cyc();
      chk("s4_no_rd", 64'(rd_q.size() - n0), 64'd0);
      chk("s4_no_drdy", 64'(drdy_cnt), 64'd0);
      pulse_pgreq(10'd7);
      wait_rd(n0 + 1, 60, "s4_rd_new");
      chk("s4_addr_new", 64'(rd_at(n0)), 64'h38);

      // Flush and pgreq together while the lookup is outstanding.
      clear_obs();
      ll_auto = 1'b0;
      ll_rd_done_i = 1'b0;
      pulse_pgreq(10'd3);
      wait_rd(8, 400, "s5_rd_seen");
      b = 0;
      while (!ll_seen && b < 60) begin
         cyc();
         b++;
      end
      chk("s5_ll_req_seen", 64'(ll_seen), 64'd1);
      repeat (3) cyc();
      pgaddr_i = 10'd5;
      pgreq_i = 1'b1;
      flush_i = 1'b1;
      cyc();
      pgreq_i = 1'b0;
      flush_i = 1'b0;
      n0 = rd_q.size();
      repeat (40) cyc();
      chk("s5_no_rd_busy", 64'(rd_q.size() - n0), 64'd0);
      chk("s5_ll_req_held", 64'(ll_rd_req_o), 64'd1);
      ll_data_i = 10'd9;
      ll_rd_done_i = 1'b1;
      cyc();
      ll_rd_done_i = 1'b0;
      chk("s5_ll_req_drop", 64'(ll_rd_req_o), 64'd0);
      wait_rd(n0 + 1, 40, "s5_rd_new");
      chk("s5_addr_new", 64'(rd_at(n0)), 64'h28);
      ll_auto = 1'b1;

      // Reset during SERVE.
      clear_obs();
      pulse_pgreq(10'd4);
      b = 0;
      while (!drdy_o && b < 60) begin
         cyc();
         b++;
      end
      chk("s6_serving", 64'(drdy_o), 64'd1);
      repeat (3) cyc();
      rst_n_i = 1'b0;
      #1;
      chk("s6_rst_drdy", 64'(drdy_o), 64'd0);
      chk("s6_rst_rd", 64'(rd_o), 64'd0);
      chk("s6_rst_q", 64'(q_o), 64'd0);
      chk("s6_rst_addr", 64'(addr_o), 64'd0);
      chk("s6_rst_state", 64'(state_o), 64'd0);
      chk("s6_rst_lladdr", 64'(ll_addr_o), 64'd0);
      repeat (2) cyc();
      rst_n_i = 1'b1;
      n0 = rd_q.size();
      drdy_cnt = 0;
      repeat (40) cyc();
      chk("s6_no_rd", 64'(rd_q.size() - n0), 64'd0);
      chk("s6_no_drdy", 64'(drdy_cnt), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
